// File: rtl/bus_xfer_seq.sv
// Two-phase register-to-register transfer sequencer for the shared CPU bus (settle, then load).
// Optional immediate source enabled by defining BUS_XFER_IMM_EN.
module bus_xfer_seq #(
  parameter int W = 16,
  parameter int NSRC = 8,
  parameter int NDST = 8,
  localparam int SRCW = $clog2(NSRC + 1)
) (
  input  logic            clk,
  input  logic            reset_bar,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SRCW-1:0] req_src,
  input  logic [NDST-1:0] req_dst,
  input  logic [W-1:0]    req_imm,
  output logic [NSRC-1:0] en_bar,
  output logic [NDST-1:0] load_bar,
  inout  wire  [W-1:0]    bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [W-1:0]    last_val
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [SRCW-1:0] src_reg, src_next;
  logic [NDST-1:0] dst_reg;
  logic            imm_sel_reg, imm_sel_next;
  logic [NSRC-1:0] en_bar_reg, en_bar_next;
  logic [NDST-1:0] load_bar_reg, load_bar_next;
  logic            done_reg, err_reg;
  logic [W-1:0]    last_val_reg;
  logic            accept, legal, src_ok, imm_req, active_next, take;

  assign req_ready = (state_reg == IDLE) || (state_reg == LOAD);
  assign accept    = req_valid && req_ready;
  assign src_ok    = req_src < SRCW'(NSRC);

`ifdef BUS_XFER_IMM_EN
  assign imm_req = (req_src == SRCW'(NSRC));
`else
  assign imm_req = 1'b0;
`endif

  assign legal = (req_dst != '0) && (src_ok || imm_req);
  assign take  = accept && legal;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = DRIVE;
      DRIVE:   state_next = LOAD;
      LOAD:    state_next = take ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign src_next     = take ? req_src : src_reg;
  assign imm_sel_next = take ? imm_req : imm_sel_reg;
  assign active_next  = (state_next != IDLE);

  // Strobes are decoded from next-state so the flops switch cleanly on one edge.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_en
      assign en_bar_next[gi] = !(active_next && !imm_sel_next && (src_next == SRCW'(gi)));
    end
    for (genvar gi = 0; gi < NDST; gi++) begin : g_load
      assign load_bar_next[gi] = !((state_next == LOAD) && dst_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_reg    <= IDLE;
      src_reg      <= '0;
      dst_reg      <= '0;
      imm_sel_reg  <= 1'b0;
      en_bar_reg   <= '1;
      load_bar_reg <= '1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      last_val_reg <= '0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      imm_sel_reg  <= imm_sel_next;
      if (take) dst_reg <= req_dst;
      en_bar_reg   <= en_bar_next;
      load_bar_reg <= load_bar_next;
      done_reg     <= (state_reg == LOAD);
      err_reg      <= accept && !legal;
      if (state_reg == LOAD) last_val_reg <= bus;
    end
  end

`ifdef BUS_XFER_IMM_EN
  logic [W-1:0] imm_reg;
  logic         drive_reg;

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      imm_reg   <= '0;
      drive_reg <= 1'b0;
    end else begin
      if (take) imm_reg <= req_imm;
      drive_reg <= active_next && imm_sel_next;
    end
  end

  assign bus = drive_reg ? imm_reg : {W{1'bz}};
`else
  logic unused_imm;
  assign unused_imm = ^req_imm;
  assign bus = {W{1'bz}};
`endif

  assign en_bar   = en_bar_reg;
  assign load_bar = load_bar_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign last_val = last_val_reg;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Scoreboard bench for bus_xfer_seq: eight bus registers modelled around the DUT.
module tb_bus_xfer_seq;

`ifdef BUS_XFER_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_bar;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_src;
  logic [7:0]  req_dst;
  logic [15:0] req_imm;
  logic [7:0]  en_bar;
  logic [7:0]  load_bar;
  wire  [15:0] bus;
  logic        busy, done, err;
  logic [15:0] last_val;

  logic [15:0] regs [8];
  logic [15:0] model [8];
  logic        preset_en, clear;
  logic [2:0]  preset_idx;
  logic [15:0] preset_val;
  logic        mon_en = 1'b0;
  logic [2:0]  drv_idx;
  logic        drv_any;

  typedef struct packed {
    logic [15:0] val;
    logic [7:0]  dst;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;

  bus_xfer_seq dut (
    .clk(clk), .reset_bar(reset_bar), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm), .en_bar(en_bar),
    .load_bar(load_bar), .bus(bus), .busy(busy), .done(done), .err(err), .last_val(last_val)
  );

  always #5 clk = ~clk;

  always_comb begin
    drv_any = 1'b0;
    drv_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!en_bar[i]) begin
        drv_any = 1'b1;
        drv_idx = 3'(i);
      end
    end
  end

  assign bus = drv_any ? regs[drv_idx] : 16'hzzzz;

  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
    end else if (preset_en) begin
      regs[preset_idx] <= preset_val;
    end else begin
      for (int i = 0; i < 8; i++) if (!load_bar[i]) regs[i] <= bus;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input int idx, input logic [15:0] val);
    preset_en  = 1'b1;
    preset_idx = 3'(idx);
    preset_val = val;
    model[idx] = val;
    tick();
    preset_en = 1'b0;
  endtask

  // Presents one request; returns in the cycle after the accept edge.
  task automatic issue(input logic [3:0] src, input logic [7:0] dst, input logic [15:0] imm,
                       input bit track);
    int   n;
    bit   legal;
    exp_t e;
    n = 0;
    while (!req_ready && n < 16) begin
      tick();
      n++;
    end
    if (!req_ready) check_val("ready_timeout", {31'd0, req_ready}, 32'd1);
    legal = (dst != 8'h00) && ((src < 4'd8) || (IMM && src == 4'd8));
    req_valid = 1'b1;
    req_src   = src;
    req_dst   = dst;
    req_imm   = imm;
    if (legal && track) begin
      e.val = (src == 4'd8) ? imm : model[src[2:0]];
      e.dst = dst;
      sb_q.push_back(e);
      for (int i = 0; i < 8; i++) if (dst[i]) model[i] = e.val;
    end
    tick();
    req_valid = 1'b0;
    req_src   = 4'($urandom_range(0, 15));
    req_dst   = 8'($urandom);
    req_imm   = 16'($urandom);
    check_val($sformatf("err src=%0d dst=%h", src, dst), {31'd0, err}, {31'd0, !legal});
  endtask

  // Scoreboard consumer plus per-cycle strobe invariant.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (mon_en) begin
        if ($countones(~en_bar) > 1) check_val("en_bar_onehot", {24'd0, en_bar}, 32'hFF);
        if (done) begin
          if (sb_q.size() == 0) begin
            check_val("done_unexpected", {31'd0, done}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_val("last_val", {16'd0, last_val}, {16'd0, e.val});
            for (int i = 0; i < 8; i++)
              if (e.dst[i]) check_val($sformatf("reg%0d", i), {16'd0, regs[i]}, {16'd0, e.val});
          end
        end
      end
    end
  end

  initial begin
    bit released;
    reset_bar = 1'b0;
    clear     = 1'b1;
    preset_en = 1'b0;
    preset_idx = 3'd0;
    preset_val = 16'h0;
    req_valid = 1'b0;
    req_src   = 4'd0;
    req_dst   = 8'h00;
    req_imm   = 16'h0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;

    // Reset state
    tick();
    tick();
    released = (bus === 16'hzzzz) || (bus === 16'h0000);
    check_val("rst en_bar", {24'd0, en_bar}, 32'hFF);
    check_val("rst load_bar", {24'd0, load_bar}, 32'hFF);
    check_val("rst busy", {31'd0, busy}, 32'd0);
    check_val("rst done", {31'd0, done}, 32'd0);
    check_val("rst err", {31'd0, err}, 32'd0);
    check_val("rst last_val", {16'd0, last_val}, 32'd0);
    check_val("rst bus released", {31'd0, released}, 32'd1);
    check_val("rst ready", {31'd0, req_ready}, 32'd1);
    reset_bar = 1'b1;
    clear     = 1'b0;
    mon_en    = 1'b1;

    // Single transfer reg2 -> reg4
    preset(2, 16'h1234);
    issue(4'd2, 8'h10, 16'h0, 1'b1);
    check_val("t2 c1 en_bar", {24'd0, en_bar}, 32'hFB);
    check_val("t2 c1 load_bar", {24'd0, load_bar}, 32'hFF);
    check_val("t2 c1 busy", {31'd0, busy}, 32'd1);
    tick();
    check_val("t2 c2 en_bar", {24'd0, en_bar}, 32'hFB);
    check_val("t2 c2 load_bar", {24'd0, load_bar}, 32'hEF);
    check_val("t2 c2 ready", {31'd0, req_ready}, 32'd1);
    tick();
    check_val("t2 c3 done", {31'd0, done}, 32'd1);
    check_val("t2 c3 en_bar", {24'd0, en_bar}, 32'hFF);
    check_val("t2 c3 load_bar", {24'd0, load_bar}, 32'hFF);
    tick();

    // Back-to-back: reg1 -> reg0, then reg0 -> reg1,reg2
    preset(0, 16'hA5A5);
    preset(1, 16'h1111);
    issue(4'd1, 8'h01, 16'h0, 1'b1);
    issue(4'd0, 8'h06, 16'h0, 1'b1);
    check_val("t3 c3 en_bar", {24'd0, en_bar}, 32'hFE);
    check_val("t3 c3 load_bar", {24'd0, load_bar}, 32'hFF);
    check_val("t3 c3 done", {31'd0, done}, 32'd1);
    tick();
    check_val("t3 c4 load_bar", {24'd0, load_bar}, 32'hF9);
    tick();
    check_val("t3 c5 done", {31'd0, done}, 32'd1);
    tick();

    // Illegal requests from IDLE
    issue(4'd3, 8'h00, 16'h0, 1'b1);
    check_val("t4 en_bar", {24'd0, en_bar}, 32'hFF);
    check_val("t4 load_bar", {24'd0, load_bar}, 32'hFF);
    check_val("t4 busy", {31'd0, busy}, 32'd0);
    tick();
    check_val("t4 err cleared", {31'd0, err}, 32'd0);
`ifndef BUS_XFER_IMM_EN
    issue(4'd8, 8'h01, 16'h0, 1'b1);
    check_val("t4b en_bar", {24'd0, en_bar}, 32'hFF);
    check_val("t4b busy", {31'd0, busy}, 32'd0);
    tick();
`endif

    // Completion and rejection in the same cycle; source also a destination
    preset(5, 16'h5A5A);
    issue(4'd5, 8'h22, 16'h0, 1'b1);
    issue(4'd2, 8'h00, 16'h0, 1'b1);
    check_val("t4c done", {31'd0, done}, 32'd1);
    check_val("t4c busy", {31'd0, busy}, 32'd0);
    tick();

`ifdef BUS_XFER_IMM_EN
    // Immediate to reg0 and reg7
    issue(4'd8, 8'h81, 16'hBEEF, 1'b1);
    check_val("t5 c1 bus", {16'd0, bus}, 32'hBEEF);
    check_val("t5 c1 en_bar", {24'd0, en_bar}, 32'hFF);
    tick();
    check_val("t5 c2 bus", {16'd0, bus}, 32'hBEEF);
    check_val("t5 c2 load_bar", {24'd0, load_bar}, 32'h7E);
    tick();
    released = (bus === 16'hzzzz) || (bus === 16'h0000);
    check_val("t5 c3 bus released", {31'd0, released}, 32'd1);
    tick();
`endif

    // Reset during DRIVE aborts the transfer
    preset(3, 16'h7777);
    issue(4'd3, 8'h20, 16'h0, 1'b0);
    check_val("t6 c1 en_bar", {24'd0, en_bar}, 32'hF7);
    reset_bar = 1'b0;
    tick();
    reset_bar = 1'b1;
    check_val("t6 en_bar", {24'd0, en_bar}, 32'hFF);
    check_val("t6 load_bar", {24'd0, load_bar}, 32'hFF);
    check_val("t6 done", {31'd0, done}, 32'd0);
    check_val("t6 busy", {31'd0, busy}, 32'd0);
    check_val("t6 last_val", {16'd0, last_val}, 32'd0);
    repeat (4) tick();
    check_val("t6 reg5 unchanged", {16'd0, regs[5]}, {16'd0, model[5]});

    for (int n = 0; n < 10 && sb_q.size() != 0; n++) tick();
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
